// File: rtl/fp_accum.sv
// fp_accum -- sequential bf16 accumulator wrapped around an external
// combinational bf16 add/sub unit.
//
// A run is started from IDLE with start_i, carrying the element count (len_i)
// and the direction (sub_i). Each accepted element replaces the running sum
// with the result returned by the external unit (add_c_i). After the last
// element the sum is presented on res_data_o with res_valid_o until the
// consumer takes it with res_ready_i.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i, len_i, sub_i     run request, element count, 1 = subtract
//   in_valid_i, in_data_i     element stream (bf16)
//   in_ready_o                element accepted when in_valid_i && in_ready_o
//   add_op_o, add_a_o/add_b_o operator and operands to the external unit
//   add_c_i                   same-cycle result from the external unit
//   res_valid_o, res_data_o   final sum, held until res_ready_i
//   res_ready_i               consumer accepts the result
//   busy_o                    high whenever a run is in progress or pending
//   nan_o                     sticky: a canonical NaN appeared in this/last run

package ibex_pkg;
    typedef enum logic [1:0] {
        FP_ALU_ADD = 2'd0,
        FP_ALU_SUB = 2'd1,
        FP_ALU_MIN = 2'd2,
        FP_ALU_MAX = 2'd3
    } fp_alu_op_e;
endpackage

module fp_accum #(
    parameter int LEN_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic                   sub_i,
    input  logic                   in_valid_i,
    input  logic [15:0]            in_data_i,
    output logic                   in_ready_o,
    output ibex_pkg::fp_alu_op_e   add_op_o,
    output logic [15:0]            add_a_o,
    output logic [15:0]            add_b_o,
    input  logic [15:0]            add_c_i,
    output logic                   res_valid_o,
    output logic [15:0]            res_data_o,
    input  logic                   res_ready_i,
    output logic                   busy_o,
    output logic                   nan_o
);

    localparam int          DATA_W = 16;
    localparam logic [DATA_W-1:0] CANON_NAN = 16'h7FC0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state;
    logic [DATA_W-1:0]  acc;
    logic [LEN_W-1:0]   cnt;
    logic               mode;
    logic               nan_q;

    // Element acceptance is a pure function of state so that the upstream
    // handshake never depends combinationally on in_valid_i.
    assign in_ready_o  = (state == ACCUM);
    assign busy_o      = (state != IDLE);
    assign res_valid_o = (state == DONE);
    assign res_data_o  = acc;
    assign nan_o       = nan_q;

    // The external unit always sees the running sum and the current input
    // word; its output is only consumed on an accepted element.
    assign add_a_o  = acc;
    assign add_b_o  = in_data_i;
    assign add_op_o = mode ? ibex_pkg::FP_ALU_SUB : ibex_pkg::FP_ALU_ADD;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            nan_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc   <= '0;
                        nan_q <= 1'b0;
                        if (len_i != '0) begin
                            cnt   <= len_i;
                            mode  <= sub_i;
                            state <= ACCUM;
                        end else begin
                            // Empty run: result 0x0000 is presented directly.
                            state <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    // Bubbles (in_valid_i low) leave every register untouched.
                    if (in_valid_i) begin
                        acc <= add_c_i;
                        cnt <= cnt - LEN_W'(1);
                        if (add_c_i == CANON_NAN) begin
                            nan_q <= 1'b1;
                        end
                        // Last element: cnt reaches 0 only as we leave ACCUM.
                        if (cnt == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start_i is deliberately not looked at here; a request
                    // coinciding with the handshake must be re-issued in IDLE.
                    if (res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
